maze_tracker: RTL

MAZE_TRACKER -- requirements
Module: maze_tracker

---
 rtl/maze_tracker.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/maze_tracker.sv
// maze_tracker: player position, move counter and checkpoint tracker for a tile maze.
// Optional macro MAZE_TRACKER_ORDER_EN: checkpoints must be reached in ascending bit order.
module maze_tracker #(
    parameter int START_TILE = 19,
    parameter int HIT_HOLD   = 32
) (
    input  logic         CLK,
    input  logic         RSTN,
    input  logic         start,
    input  logic         tick,
    input  logic [3:0]   btn,
    input  logic [197:0] mazestate,
    output logic [7:0]   player_tile,
    output logic [7:0]   counter,
    output logic [4:0]   cp_mask,
    output logic         win,
    output logic [1:0]   fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        HIT  = 2'd2,
        WIN  = 2'd3
    } state_t;

    localparam logic [4:0] START_COL = 5'(START_TILE % 18);
    localparam logic [3:0] START_ROW = 4'(START_TILE / 18);

    state_t      state;
    logic [4:0]  col;
    logic [3:0]  row;
    logic [7:0]  saved;
    logic [15:0] hold;

    logic [4:0]  ncol;
    logic [3:0]  nrow;
    logic        blocked;
    logic        moving;
    logic [7:0]  cand;
    logic        path;
    logic [4:0]  cp_hit;
    logic [4:0]  allow;
    logic [4:0]  mask_next;

    assign player_tile = 8'({3'd0, col}) + 8'(8'd18 * {4'd0, row});
    assign fsm_state   = state;

    // Candidate tile for the highest-priority pressed direction, plus grid-edge blocking
    always_comb begin
        ncol    = col;
        nrow    = row;
        blocked = 1'b0;
        if (btn[3]) begin
            if (row == 4'd0) blocked = 1'b1;
            else nrow = row - 4'd1;
        end else if (btn[2]) begin
            if (row == 4'd10) blocked = 1'b1;
            else nrow = row + 4'd1;
        end else if (btn[1]) begin
            if (col == 5'd0) blocked = 1'b1;
            else ncol = col - 5'd1;
        end else if (btn[0]) begin
            if (col == 5'd17) blocked = 1'b1;
            else ncol = col + 5'd1;
        end
        moving = (|btn) && !blocked;
        cand   = 8'({3'd0, ncol}) + 8'(8'd18 * {4'd0, nrow});
        path   = mazestate[cand];
    end

    // Checkpoint detection and the mask that a path move onto cand would produce
    always_comb begin
        cp_hit = {cand == 8'd178, cand == 8'd139, cand == 8'd113,
                  cand == 8'd37, cand == 8'd31};
`ifdef MAZE_TRACKER_ORDER_EN
        allow = {&cp_mask[3:0], &cp_mask[2:0], &cp_mask[1:0],
                 cp_mask[0], 1'b1};
`else
        allow = 5'b11111;
`endif
        mask_next = cp_mask | (cp_hit & allow);
    end

    // Game FSM with all visible state held in registers
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state   <= IDLE;
            col     <= START_COL;
            row     <= START_ROW;
            counter <= 8'd0;
            saved   <= 8'd0;
            cp_mask <= 5'd0;
            win     <= 1'b0;
            hold    <= 16'd0;
        end else begin
            case (state)
                IDLE, WIN: begin
                    if (start) begin
                        state   <= PLAY;
                        col     <= START_COL;
                        row     <= START_ROW;
                        counter <= 8'd0;
                        cp_mask <= 5'd0;
                        win     <= 1'b0;
                        hold    <= 16'd0;
                    end
                end
                PLAY: begin
                    if (tick && moving) begin
                        if (path) begin
                            col     <= ncol;
                            row     <= nrow;
                            counter <= (counter < 8'd254) ?
                                       counter + 8'd1 : 8'd254;
                            cp_mask <= mask_next;
                            if (mask_next == 5'b11111) begin
                                state <= WIN;
                                win   <= 1'b1;
                            end
                        end else begin
                            state   <= HIT;
                            saved   <= counter;
                            counter <= 8'd255;
                            hold    <= 16'(HIT_HOLD);
                        end
                    end
                end
                HIT: begin
                    if (tick) begin
                        if (hold <= 16'd1) begin
                            state   <= PLAY;
                            col     <= START_COL;
                            row     <= START_ROW;
                            counter <= saved;
                            hold    <= 16'd0;
                        end else begin
                            hold <= hold - 16'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
